// File: rtl/dsp_pkg.sv
// Shared types and width helpers for the read-data ordered router.
// Default configuration values and the buffered beat layout {RID,RDATA,RRESP,RLAST}.
package dsp_pkg;

   localparam int DEF_SLV_AMT        = 2;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_TRANS_MST_ID_W = 5;
   localparam int DEF_RESP_W         = 2;
   localparam int DEF_RDATA_DEPTH    = 16;
   localparam int DEF_OUTST_DEPTH    = 8;

   function automatic int slv_id_w(input int slv_amt);
      return (slv_amt > 1) ? $clog2(slv_amt) : 1;
   endfunction

   localparam int DEF_SLV_ID_W = slv_id_w(DEF_SLV_AMT);

   typedef struct packed {
      logic [DEF_TRANS_MST_ID_W-1:0] rid;
      logic [DEF_DATA_WIDTH-1:0]     rdata;
      logic [DEF_RESP_W-1:0]         rresp;
      logic                          rlast;
   } rdata_info_t;

endpackage

// File: rtl/sync_fifo_ah.sv
// Synchronous FIFO, async active-high reset, registered pointers with wrap bit, comb head read.
// Write is ignored while full, read ignored while empty; storage itself is not reset.
module sync_fifo_ah #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   // Same index, different lap bit: writer is a full lap ahead.
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty  = (wr_ptr == rd_ptr);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dsp_rdata_ordered_router.sv
// Per-slave R beat buffers drained onto the master strictly in AR-issue order.
// Slave beat visible on master one cycle after its handshake; per-slave RREADY drops when its buffer fills.
module dsp_rdata_ordered_router
   import dsp_pkg::*;
#(
   parameter int SLV_AMT        = DEF_SLV_AMT,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TRANS_MST_ID_W = DEF_TRANS_MST_ID_W,
   parameter int RESP_W         = DEF_RESP_W,
   parameter int RDATA_DEPTH    = DEF_RDATA_DEPTH,
   parameter int OUTST_DEPTH    = DEF_OUTST_DEPTH,
   parameter int SLV_ID_W       = slv_id_w(SLV_AMT)
) (
   input  logic                               ACLK_i,
   input  logic                               ARESET_i,
   input  logic                               ar_push_i,
   input  logic [SLV_ID_W-1:0]                ar_slv_id_i,
   output logic                               ar_ready_o,
   output logic [$clog2(OUTST_DEPTH+1)-1:0]   outst_cnt_o,
   input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]  sa_RID_i,
   input  logic [DATA_WIDTH*SLV_AMT-1:0]      sa_RDATA_i,
   input  logic [RESP_W*SLV_AMT-1:0]          sa_RRESP_i,
   input  logic [SLV_AMT-1:0]                 sa_RLAST_i,
   input  logic [SLV_AMT-1:0]                 sa_RVALID_i,
   output logic [SLV_AMT-1:0]                 sa_RREADY_o,
   output logic [TRANS_MST_ID_W-1:0]          m_RID_o,
   output logic [DATA_WIDTH-1:0]              m_RDATA_o,
   output logic [RESP_W-1:0]                  m_RRESP_o,
   output logic                               m_RLAST_o,
   output logic                               m_RVALID_o,
   input  logic                               m_RREADY_i,
   output logic                               r_burst_done_o
);

   localparam int CNT_W = $clog2(OUTST_DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTST_DEPTH);

   typedef struct packed {
      logic [TRANS_MST_ID_W-1:0] rid;
      logic [DATA_WIDTH-1:0]     rdata;
      logic [RESP_W-1:0]         rresp;
      logic                      rlast;
   } beat_t;

   beat_t               wr_beat [SLV_AMT];
   beat_t               rd_beat [SLV_AMT];
   beat_t               head_beat;
   logic [SLV_AMT-1:0]  fifo_full;
   logic [SLV_AMT-1:0]  fifo_empty;
   logic [SLV_AMT-1:0]  fifo_rd;
   logic [SLV_ID_W-1:0] head_id;
   logic                oq_full;
   logic                oq_empty;
   logic                head_vld;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    outst_cnt;

   for (genvar k = 0; k < SLV_AMT; k++) begin : g_slv
      assign wr_beat[k] = '{rid:   sa_RID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                            rdata: sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH],
                            rresp: sa_RRESP_i[k*RESP_W +: RESP_W],
                            rlast: sa_RLAST_i[k]};

      sync_fifo_ah #(.WIDTH($bits(beat_t)), .DEPTH(RDATA_DEPTH)) u_beat_fifo (
         .clk    (ACLK_i),
         .rst    (ARESET_i),
         .wr_en  (sa_RVALID_i[k]),
         .wr_dat (wr_beat[k]),
         .rd_en  (fifo_rd[k]),
         .rd_dat (rd_beat[k]),
         .full   (fifo_full[k]),
         .empty  (fifo_empty[k])
      );

      assign sa_RREADY_o[k] = ~fifo_full[k];
   end

   sync_fifo_ah #(.WIDTH(SLV_ID_W), .DEPTH(OUTST_DEPTH)) u_order_q (
      .clk    (ACLK_i),
      .rst    (ARESET_i),
      .wr_en  (push),
      .wr_dat (ar_slv_id_i),
      .rd_en  (pop),
      .rd_dat (head_id),
      .full   (oq_full),
      .empty  (oq_empty)
   );

   // Only the slave named at the queue head may reach the master; payload is zero when nothing is valid.
   always_comb begin
      head_vld  = 1'b0;
      head_beat = '0;
      fifo_rd   = '0;
      for (int k = 0; k < SLV_AMT; k++) begin
         if (!oq_empty && head_id == SLV_ID_W'(k) && !fifo_empty[k]) begin
            head_vld   = 1'b1;
            head_beat  = rd_beat[k];
            fifo_rd[k] = m_RREADY_i;
         end
      end
   end

   assign push = ar_push_i & ar_ready_o;
   assign pop  = head_vld & m_RREADY_i & head_beat.rlast;

   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         outst_cnt <= '0;
      end else if (push && !pop) begin
         outst_cnt <= outst_cnt + CNT_ONE;
      end else if (pop && !push) begin
         outst_cnt <= outst_cnt - CNT_ONE;
      end
   end

   assign ar_ready_o     = (outst_cnt != CNT_MAX) & ~oq_full;
   assign outst_cnt_o    = outst_cnt;
   assign m_RVALID_o     = head_vld;
   assign m_RID_o        = head_beat.rid;
   assign m_RDATA_o      = head_beat.rdata;
   assign m_RRESP_o      = head_beat.rresp;
   assign m_RLAST_o      = head_beat.rlast;
   assign r_burst_done_o = pop;

endmodule

// File: tb/tb_dsp_rdata_ordered_router.sv
// Directed bench for dsp_rdata_ordered_router: ordering, backpressure, queue limits, stall and reset.
module tb_dsp_rdata_ordered_router;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_push;
   logic [0:0]  ar_id;
   logic        ar_ready;
   logic [3:0]  outst;
   logic [9:0]  sa_rid;
   logic [63:0] sa_rdata;
   logic [3:0]  sa_rresp;
   logic [1:0]  sa_rlast;
   logic [1:0]  sa_rvalid;
   logic [1:0]  sa_rready;
   logic [4:0]  m_rid;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic        m_rvalid;
   logic        m_rready;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dsp_rdata_ordered_router dut (
      .ACLK_i         (clk),
      .ARESET_i       (rst),
      .ar_push_i      (ar_push),
      .ar_slv_id_i    (ar_id),
      .ar_ready_o     (ar_ready),
      .outst_cnt_o    (outst),
      .sa_RID_i       (sa_rid),
      .sa_RDATA_i     (sa_rdata),
      .sa_RRESP_i     (sa_rresp),
      .sa_RLAST_i     (sa_rlast),
      .sa_RVALID_i    (sa_rvalid),
      .sa_RREADY_o    (sa_rready),
      .m_RID_o        (m_rid),
      .m_RDATA_o      (m_rdata),
      .m_RRESP_o      (m_rresp),
      .m_RLAST_o      (m_rlast),
      .m_RVALID_o     (m_rvalid),
      .m_RREADY_i     (m_rready),
      .r_burst_done_o (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int k, input logic [4:0] rid, input logic [31:0] d,
                       input logic [1:0] resp, input logic last);
      sa_rvalid[k]         = 1'b1;
      sa_rid[k*5 +: 5]     = rid;
      sa_rdata[k*32 +: 32] = d;
      sa_rresp[k*2 +: 2]   = resp;
      sa_rlast[k]          = last;
   endtask

   initial begin
      rst = 1'b1; ar_push = 1'b0; ar_id = 1'b0; m_rready = 1'b0;
      sa_rid = '0; sa_rdata = '0; sa_rresp = '0; sa_rlast = '0; sa_rvalid = '0;
      tick(); tick(); #1;
      chk("rst_rvalid", m_rvalid, 0);
      chk("rst_sardy", sa_rready, 2'b11);
      chk("rst_arrdy", ar_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_outst", outst, 0);
      chk("rst_rdata", m_rdata, 0);
      rst = 1'b0;
      tick();

      // Single burst of four beats from slave 1
      m_rready = 1'b1; ar_push = 1'b1; ar_id = 1'b1;
      tick();
      ar_push = 1'b0; #1;
      chk("t1_outst1", outst, 1);
      chk("t1_idle", m_rvalid, 0);
      for (int i = 0; i < 4; i++) begin
         beat(1, 5'd4, 32'h1000 + i, 2'b00, i == 3);
         tick(); #1;
         chk("t1_rvalid", m_rvalid, 1);
         chk("t1_rdata", m_rdata, 32'h1000 + i);
         chk("t1_rid", m_rid, 5'd4);
         chk("t1_rlast", m_rlast, i == 3);
         chk("t1_done", done, i == 3);
      end
      sa_rvalid = '0;
      tick(); #1;
      chk("t1_end_rvalid", m_rvalid, 0);
      chk("t1_end_outst", outst, 0);

      // Ordering: slave 0 issued first, slave 1 answers first
      ar_push = 1'b1; ar_id = 1'b0;
      tick();
      ar_id = 1'b1;
      tick();
      ar_push = 1'b0; #1;
      chk("t2_outst2", outst, 2);
      for (int i = 0; i < 2; i++) begin
         beat(1, 5'd9, 32'h2100 + i, 2'b01, i == 1);
         tick(); #1;
         chk("t2_hold", m_rvalid, 0);
      end
      sa_rvalid = '0;
      for (int i = 0; i < 2; i++) begin
         beat(0, 5'd3, 32'h2000 + i, 2'b00, i == 1);
         tick(); #1;
         chk("t2_s0_rvalid", m_rvalid, 1);
         chk("t2_s0_rdata", m_rdata, 32'h2000 + i);
         chk("t2_s0_rid", m_rid, 5'd3);
         chk("t2_s0_done", done, i == 1);
      end
      sa_rvalid = '0;
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         chk("t2_s1_rvalid", m_rvalid, 1);
         chk("t2_s1_rdata", m_rdata, 32'h2100 + i);
         chk("t2_s1_rresp", m_rresp, 2'b01);
         chk("t2_s1_done", done, i == 1);
      end
      tick(); #1;
      chk("t2_end_rvalid", m_rvalid, 0);
      chk("t2_end_outst", outst, 0);

      // Backpressure: fill slave 0 buffer, stall, then drain
      m_rready = 1'b0; ar_push = 1'b1; ar_id = 1'b0;
      tick();
      ar_push = 1'b0;
      for (int i = 0; i < 16; i++) begin
         beat(0, 5'd7, 32'h300 + i, 2'b10, i == 15);
         tick(); #1;
         chk("t3_sardy", sa_rready[0], i < 15);
      end
      beat(0, 5'd7, 32'hDEAD, 2'b11, 1'b1);
      for (int c = 0; c < 5; c++) begin
         tick(); #1;
         chk("t3_stall_rvalid", m_rvalid, 1);
         chk("t3_stall_rdata", m_rdata, 32'h300);
         chk("t3_stall_rid", m_rid, 5'd7);
         chk("t3_stall_rresp", m_rresp, 2'b10);
         chk("t3_stall_rlast", m_rlast, 0);
         chk("t3_stall_full", sa_rready[0], 0);
      end
      sa_rvalid = '0; m_rready = 1'b1; #1;
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain_rvalid", m_rvalid, 1);
         chk("t3_drain_rdata", m_rdata, 32'h300 + i);
         chk("t3_drain_rlast", m_rlast, i == 15);
         tick(); #1;
      end
      chk("t3_end_rvalid", m_rvalid, 0);
      chk("t3_end_outst", outst, 0);
      chk("t3_end_sardy", sa_rready, 2'b11);

      // Order queue limits
      ar_push = 1'b1; ar_id = 1'b0;
      repeat (8) tick();
      ar_push = 1'b0; #1;
      chk("t4_outst8", outst, 8);
      chk("t4_full_arrdy", ar_ready, 0);
      ar_push = 1'b1;
      tick();
      ar_push = 1'b0; #1;
      chk("t4_ninth_ignored", outst, 8);
      beat(0, 5'd1, 32'hA0, 2'b00, 1'b1);
      tick();
      sa_rvalid = '0; ar_push = 1'b1; #1;
      chk("t4_pop_full_done", done, 1);
      tick();
      ar_push = 1'b0; #1;
      chk("t4_pop_full_outst", outst, 7);
      chk("t4_arrdy_back", ar_ready, 1);
      beat(0, 5'd1, 32'hA1, 2'b00, 1'b1);
      tick();
      sa_rvalid = '0; ar_push = 1'b1; #1;
      chk("t4_pushpop_done", done, 1);
      tick();
      ar_push = 1'b0; #1;
      chk("t4_pushpop_outst", outst, 7);

      // Clear leftovers, then reset in the middle of a burst
      rst = 1'b1; #1;
      chk("t5_clr_outst", outst, 0);
      tick();
      rst = 1'b0;
      tick();
      ar_push = 1'b1; ar_id = 1'b1; m_rready = 1'b0;
      tick();
      ar_push = 1'b0;
      beat(1, 5'd2, 32'h500, 2'b00, 1'b0);
      tick();
      beat(1, 5'd2, 32'h501, 2'b00, 1'b0);
      tick(); #1;
      chk("t5_pre_rvalid", m_rvalid, 1);
      chk("t5_pre_rdata", m_rdata, 32'h500);
      sa_rvalid = '0; rst = 1'b1; #1;
      chk("t5_rst_rvalid", m_rvalid, 0);
      chk("t5_rst_outst", outst, 0);
      chk("t5_rst_sardy", sa_rready, 2'b11);
      chk("t5_rst_arrdy", ar_ready, 1);
      chk("t5_rst_rdata", m_rdata, 0);
      tick();
      rst = 1'b0; m_rready = 1'b1;
      tick();
      ar_push = 1'b1; ar_id = 1'b1;
      tick();
      ar_push = 1'b0;
      for (int i = 0; i < 2; i++) begin
         beat(1, 5'd6, 32'h600 + i, 2'b00, i == 1);
         tick(); #1;
         chk("t5_post_rdata", m_rdata, 32'h600 + i);
         chk("t5_post_done", done, i == 1);
      end
      sa_rvalid = '0;
      tick(); #1;
      chk("t5_post_rvalid", m_rvalid, 0);
      chk("t5_post_outst", outst, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
